// File: rtl/aes_sbox_word_if.sv
// aes_sbox_word_if: word and valid bundle between the S-box stage and its neighbours
interface aes_sbox_word_if;
    logic [31:0] i_wrd_sbox;
    logic        i_vld;
    logic [31:0] o_wrd_sbox;
    logic [31:0] o_wrd_sbox_r;
    logic        o_vld_r;
    modport master (output i_wrd_sbox, i_vld, input o_wrd_sbox, o_wrd_sbox_r, o_vld_r);
    modport slave (input i_wrd_sbox, i_vld, output o_wrd_sbox, o_wrd_sbox_r, o_vld_r);
endinterface

// File: rtl/aes_sbox_word.sv
// aes_sbox_word: AES forward S-box on four byte lanes, combinational plus one-cycle registered output
module aes_sbox_word (
    input logic            i_clk,
    input logic            i_rst,
    aes_sbox_word_if.slave bus
);
    function automatic logic [7:0] sbox(input logic [7:0] b);
        case (b)
            8'h00: sbox = 8'h63;
            8'h01: sbox = 8'h7c;
            8'h02: sbox = 8'h77;
            8'h03: sbox = 8'h7b;
            8'h04: sbox = 8'hf2;
            8'h05: sbox = 8'h6b;
            8'h06: sbox = 8'h6f;
            8'h07: sbox = 8'hc5;
            8'h08: sbox = 8'h30;
            8'h09: sbox = 8'h01;
            8'h0a: sbox = 8'h67;
            8'h0b: sbox = 8'h2b;
            8'h0c: sbox = 8'hfe;
            8'h0d: sbox = 8'hd7;
            8'h0e: sbox = 8'hab;
            8'h0f: sbox = 8'h76;
            8'h10: sbox = 8'hca;
            8'h11: sbox = 8'h82;
            8'h12: sbox = 8'hc9;
            8'h13: sbox = 8'h7d;
            8'h14: sbox = 8'hfa;
            8'h15: sbox = 8'h59;
            8'h16: sbox = 8'h47;
            8'h17: sbox = 8'hf0;
            8'h18: sbox = 8'had;
            8'h19: sbox = 8'hd4;
            8'h1a: sbox = 8'ha2;
            8'h1b: sbox = 8'haf;
            8'h1c: sbox = 8'h9c;
            8'h1d: sbox = 8'ha4;
            8'h1e: sbox = 8'h72;
            8'h1f: sbox = 8'hc0;
            8'h20: sbox = 8'hb7;
            8'h21: sbox = 8'hfd;
            8'h22: sbox = 8'h93;
            8'h23: sbox = 8'h26;
            8'h24: sbox = 8'h36;
            8'h25: sbox = 8'h3f;
            8'h26: sbox = 8'hf7;
            8'h27: sbox = 8'hcc;
            8'h28: sbox = 8'h34;
            8'h29: sbox = 8'ha5;
            8'h2a: sbox = 8'he5;
            8'h2b: sbox = 8'hf1;
            8'h2c: sbox = 8'h71;
            8'h2d: sbox = 8'hd8;
            8'h2e: sbox = 8'h31;
            8'h2f: sbox = 8'h15;
            8'h30: sbox = 8'h04;
            8'h31: sbox = 8'hc7;
            8'h32: sbox = 8'h23;
            8'h33: sbox = 8'hc3;
            8'h34: sbox = 8'h18;
            8'h35: sbox = 8'h96;
            8'h36: sbox = 8'h05;
            8'h37: sbox = 8'h9a;
            8'h38: sbox = 8'h07;
            8'h39: sbox = 8'h12;
            8'h3a: sbox = 8'h80;
            8'h3b: sbox = 8'he2;
            8'h3c: sbox = 8'heb;
            8'h3d: sbox = 8'h27;
            8'h3e: sbox = 8'hb2;
            8'h3f: sbox = 8'h75;
            8'h40: sbox = 8'h09;
            8'h41: sbox = 8'h83;
            8'h42: sbox = 8'h2c;
            8'h43: sbox = 8'h1a;
            8'h44: sbox = 8'h1b;
            8'h45: sbox = 8'h6e;
            8'h46: sbox = 8'h5a;
            8'h47: sbox = 8'ha0;
            8'h48: sbox = 8'h52;
            8'h49: sbox = 8'h3b;
            8'h4a: sbox = 8'hd6;
            8'h4b: sbox = 8'hb3;
            8'h4c: sbox = 8'h29;
            8'h4d: sbox = 8'he3;
            8'h4e: sbox = 8'h2f;
            8'h4f: sbox = 8'h84;
            8'h50: sbox = 8'h53;
            8'h51: sbox = 8'hd1;
            8'h52: sbox = 8'h00;
            8'h53: sbox = 8'hed;
            8'h54: sbox = 8'h20;
            8'h55: sbox = 8'hfc;
            8'h56: sbox = 8'hb1;
            8'h57: sbox = 8'h5b;
            8'h58: sbox = 8'h6a;
            8'h59: sbox = 8'hcb;
            8'h5a: sbox = 8'hbe;
            8'h5b: sbox = 8'h39;
            8'h5c: sbox = 8'h4a;
            8'h5d: sbox = 8'h4c;
            8'h5e: sbox = 8'h58;
            8'h5f: sbox = 8'hcf;
            8'h60: sbox = 8'hd0;
            8'h61: sbox = 8'hef;
            8'h62: sbox = 8'haa;
            8'h63: sbox = 8'hfb;
            8'h64: sbox = 8'h43;
            8'h65: sbox = 8'h4d;
            8'h66: sbox = 8'h33;
            8'h67: sbox = 8'h85;
            8'h68: sbox = 8'h45;
            8'h69: sbox = 8'hf9;
            8'h6a: sbox = 8'h02;
            8'h6b: sbox = 8'h7f;
            8'h6c: sbox = 8'h50;
            8'h6d: sbox = 8'h3c;
            8'h6e: sbox = 8'h9f;
            8'h6f: sbox = 8'ha8;
            8'h70: sbox = 8'h51;
            8'h71: sbox = 8'ha3;
            8'h72: sbox = 8'h40;
            8'h73: sbox = 8'h8f;
            8'h74: sbox = 8'h92;
            8'h75: sbox = 8'h9d;
            8'h76: sbox = 8'h38;
            8'h77: sbox = 8'hf5;
            8'h78: sbox = 8'hbc;
            8'h79: sbox = 8'hb6;
            8'h7a: sbox = 8'hda;
            8'h7b: sbox = 8'h21;
            8'h7c: sbox = 8'h10;
            8'h7d: sbox = 8'hff;
            8'h7e: sbox = 8'hf3;
            8'h7f: sbox = 8'hd2;
            8'h80: sbox = 8'hcd;
            8'h81: sbox = 8'h0c;
            8'h82: sbox = 8'h13;
            8'h83: sbox = 8'hec;
            8'h84: sbox = 8'h5f;
            8'h85: sbox = 8'h97;
            8'h86: sbox = 8'h44;
            8'h87: sbox = 8'h17;
            8'h88: sbox = 8'hc4;
            8'h89: sbox = 8'ha7;
            8'h8a: sbox = 8'h7e;
            8'h8b: sbox = 8'h3d;
            8'h8c: sbox = 8'h64;
            8'h8d: sbox = 8'h5d;
            8'h8e: sbox = 8'h19;
            8'h8f: sbox = 8'h73;
            8'h90: sbox = 8'h60;
            8'h91: sbox = 8'h81;
            8'h92: sbox = 8'h4f;
            8'h93: sbox = 8'hdc;
            8'h94: sbox = 8'h22;
            8'h95: sbox = 8'h2a;
            8'h96: sbox = 8'h90;
            8'h97: sbox = 8'h88;
            8'h98: sbox = 8'h46;
            8'h99: sbox = 8'hee;
            8'h9a: sbox = 8'hb8;
            8'h9b: sbox = 8'h14;
            8'h9c: sbox = 8'hde;
            8'h9d: sbox = 8'h5e;
            8'h9e: sbox = 8'h0b;
            8'h9f: sbox = 8'hdb;
            8'ha0: sbox = 8'he0;
            8'ha1: sbox = 8'h32;
            8'ha2: sbox = 8'h3a;
            8'ha3: sbox = 8'h0a;
            8'ha4: sbox = 8'h49;
            8'ha5: sbox = 8'h06;
            8'ha6: sbox = 8'h24;
            8'ha7: sbox = 8'h5c;
            8'ha8: sbox = 8'hc2;
            8'ha9: sbox = 8'hd3;
            8'haa: sbox = 8'hac;
            8'hab: sbox = 8'h62;
            8'hac: sbox = 8'h91;
            8'had: sbox = 8'h95;
            8'hae: sbox = 8'he4;
            8'haf: sbox = 8'h79;
            8'hb0: sbox = 8'he7;
            8'hb1: sbox = 8'hc8;
            8'hb2: sbox = 8'h37;
            8'hb3: sbox = 8'h6d;
            8'hb4: sbox = 8'h8d;
            8'hb5: sbox = 8'hd5;
            8'hb6: sbox = 8'h4e;
            8'hb7: sbox = 8'ha9;
            8'hb8: sbox = 8'h6c;
            8'hb9: sbox = 8'h56;
            8'hba: sbox = 8'hf4;
            8'hbb: sbox = 8'hea;
            8'hbc: sbox = 8'h65;
            8'hbd: sbox = 8'h7a;
            8'hbe: sbox = 8'hae;
            8'hbf: sbox = 8'h08;
            8'hc0: sbox = 8'hba;
            8'hc1: sbox = 8'h78;
            8'hc2: sbox = 8'h25;
            8'hc3: sbox = 8'h2e;
            8'hc4: sbox = 8'h1c;
            8'hc5: sbox = 8'ha6;
            8'hc6: sbox = 8'hb4;
            8'hc7: sbox = 8'hc6;
            8'hc8: sbox = 8'he8;
            8'hc9: sbox = 8'hdd;
            8'hca: sbox = 8'h74;
            8'hcb: sbox = 8'h1f;
            8'hcc: sbox = 8'h4b;
            8'hcd: sbox = 8'hbd;
            8'hce: sbox = 8'h8b;
            8'hcf: sbox = 8'h8a;
            8'hd0: sbox = 8'h70;
            8'hd1: sbox = 8'h3e;
            8'hd2: sbox = 8'hb5;
            8'hd3: sbox = 8'h66;
            8'hd4: sbox = 8'h48;
            8'hd5: sbox = 8'h03;
            8'hd6: sbox = 8'hf6;
            8'hd7: sbox = 8'h0e;
            8'hd8: sbox = 8'h61;
            8'hd9: sbox = 8'h35;
            8'hda: sbox = 8'h57;
            8'hdb: sbox = 8'hb9;
            8'hdc: sbox = 8'h86;
            8'hdd: sbox = 8'hc1;
            8'hde: sbox = 8'h1d;
            8'hdf: sbox = 8'h9e;
            8'he0: sbox = 8'he1;
            8'he1: sbox = 8'hf8;
            8'he2: sbox = 8'h98;
            8'he3: sbox = 8'h11;
            8'he4: sbox = 8'h69;
            8'he5: sbox = 8'hd9;
            8'he6: sbox = 8'h8e;
            8'he7: sbox = 8'h94;
            8'he8: sbox = 8'h9b;
            8'he9: sbox = 8'h1e;
            8'hea: sbox = 8'h87;
            8'heb: sbox = 8'he9;
            8'hec: sbox = 8'hce;
            8'hed: sbox = 8'h55;
            8'hee: sbox = 8'h28;
            8'hef: sbox = 8'hdf;
            8'hf0: sbox = 8'h8c;
            8'hf1: sbox = 8'ha1;
            8'hf2: sbox = 8'h89;
            8'hf3: sbox = 8'h0d;
            8'hf4: sbox = 8'hbf;
            8'hf5: sbox = 8'he6;
            8'hf6: sbox = 8'h42;
            8'hf7: sbox = 8'h68;
            8'hf8: sbox = 8'h41;
            8'hf9: sbox = 8'h99;
            8'hfa: sbox = 8'h2d;
            8'hfb: sbox = 8'h0f;
            8'hfc: sbox = 8'hb0;
            8'hfd: sbox = 8'h54;
            8'hfe: sbox = 8'hbb;
            8'hff: sbox = 8'h16;
            default: sbox = 8'hxx;
        endcase
    endfunction

    logic [31:0] sub_w, wrd_d, wrd_q;
    logic        vld_d, vld_q;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign sub_w[8*k +: 8] = sbox(bus.i_wrd_sbox[8*k +: 8]);
    end

    always_comb begin
        wrd_d = bus.i_vld ? sub_w : wrd_q;
        vld_d = bus.i_vld;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wrd_q <= 32'h0;
            vld_q <= 1'b0;
        end else begin
            wrd_q <= wrd_d;
            vld_q <= vld_d;
        end
    end

    assign bus.o_wrd_sbox   = sub_w;
    assign bus.o_wrd_sbox_r = wrd_q;
    assign bus.o_vld_r      = vld_q;
endmodule

// File: tb/tb_aes_sbox_word.sv
// tb_aes_sbox_word: scoreboard bench checking S-box lanes against a GF(2^8) inverse/affine model
module tb_aes_sbox_word;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_err = 0;
    int vld_cnt = 0;
    logic [7:0] ref_tab [256];
    logic [31:0] exp_q [$];
    logic [31:0] r1_in [4] = '{32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808};
    logic [31:0] r1_out [4] = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
    logic [127:0] cat;
    logic [31:0] w, e;

    aes_sbox_word_if bus ();
    aes_sbox_word dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.o_vld_r) begin
            vld_cnt++;
            if (exp_q.size() == 0) check("vld_spurious", 128'(bus.o_vld_r), 128'h0);
            else check("reg_word", 128'(bus.o_wrd_sbox_r), 128'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_vld = 1'b0;
        bus.i_wrd_sbox = 32'h0;
        for (int i = 0; i < 256; i++) ref_tab[i] = ref_sbox(8'(i));
        #2;
        check("rst_wrd", 128'(bus.o_wrd_sbox_r), 128'h0);
        check("rst_vld", 128'(bus.o_vld_r), 128'h0);
        for (int i = 0; i < 4; i++) begin
            bus.i_wrd_sbox = r1_in[i];
            #5;
            check("round1", 128'(bus.o_wrd_sbox), 128'(r1_out[i]));
            cat[127-32*i -: 32] = bus.o_wrd_sbox;
        end
        check("round1_cat", cat, 128'hd42711aee0bf98f1b8b45de51e415230);
        bus.i_wrd_sbox = 32'h00000000; #5;
        check("corner_00", 128'(bus.o_wrd_sbox), 128'h63636363);
        bus.i_wrd_sbox = 32'hffffffff; #5;
        check("corner_ff", 128'(bus.o_wrd_sbox), 128'h16161616);
        bus.i_wrd_sbox = 32'h00015300; #5;
        check("corner_lane", 128'(bus.o_wrd_sbox), 128'h637ced63);
        for (int k = 0; k < 4; k++)
            for (int v = 0; v < 256; v++) begin
                w = 32'h0;
                w[8*k +: 8] = 8'(v);
                e = 32'h63636363;
                e[8*k +: 8] = ref_tab[v];
                bus.i_wrd_sbox = w;
                #1;
                check($sformatf("sweep_l%0d_%02h", k, v), 128'(bus.o_wrd_sbox), 128'(e));
            end
        check("rst_hold", 128'(bus.o_vld_r), 128'h0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.i_vld = 1'b1;
            bus.i_wrd_sbox = r1_in[i];
            exp_q.push_back(r1_out[i]);
        end
        @(negedge clk);
        bus.i_vld = 1'b0;
        bus.i_wrd_sbox = 32'h12345678;
        repeat (3) @(negedge clk);
        check("vld_cnt", 128'(vld_cnt), 128'd4);
        check("hold_wrd", 128'(bus.o_wrd_sbox_r), 128'h1e415230);
        check("hold_vld", 128'(bus.o_vld_r), 128'h0);
        bus.i_vld = 1'b1;
        bus.i_wrd_sbox = r1_in[0];
        @(posedge clk) #2;
        check("pre_arst_vld", 128'(bus.o_vld_r), 128'h1);
        rst = 1'b1;
        #1;
        check("arst_wrd", 128'(bus.o_wrd_sbox_r), 128'h0);
        check("arst_vld", 128'(bus.o_vld_r), 128'h0);
        check("arst_comb", 128'(bus.o_wrd_sbox), 128'hd42711ae);
        bus.i_wrd_sbox = 32'h00015300;
        #1;
        check("arst_comb2", 128'(bus.o_wrd_sbox), 128'h637ced63);
        @(posedge clk) #1;
        check("arst_hold", 128'(bus.o_vld_r), 128'h0);
        @(negedge clk);
        rst = 1'b0;
        bus.i_wrd_sbox = r1_in[2];
        exp_q.push_back(r1_out[2]);
        @(posedge clk) #1;
        check("post_rst_vld", 128'(bus.o_vld_r), 128'h1);
        check("post_rst_wrd", 128'(bus.o_wrd_sbox_r), 128'hb8b45de5);
        @(negedge clk);
        bus.i_vld = 1'b0;
        repeat (2) @(negedge clk);
        check("q_empty", 128'(exp_q.size()), 128'h0);
        check("vld_cnt_end", 128'(vld_cnt), 128'd5);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/aes_sbox_word.md
# aes_sbox_word

Word-wide AES forward S-box (FIPS-197 SubBytes applied to one 32-bit word). It substitutes each of four bytes independently through the AES S-box. The block serves the SubBytes stage of the AES round datapath and the SubWord step of key expansion in the AES-GCM core. It has a zero-latency combinational output and a one-cycle registered output with a valid flag.

## Interface
- No parameters. Word width is fixed at 32 bits, as 4 bytes.
- i_clk  input  1  clock for the registered path, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wrd_sbox  input  32  word to substitute. Byte 3 is [31:24], byte 0 is [7:0].
- i_vld  input  1  qualifies i_wrd_sbox for the registered path.
- o_wrd_sbox  output  32  combinational substituted word.
- o_wrd_sbox_r  output  32  registered substituted word.
- o_vld_r  output  1  o_wrd_sbox_r holds a valid result.

## Operation
- o_wrd_sbox[8k+7:8k] = SBOX(i_wrd_sbox[8k+7:8k]) for k = 0..3.
- SBOX is the FIPS-197 forward table: the multiplicative inverse in GF(2^8) with polynomial 0x11B (where 0 maps to 0), followed by the affine transform with constant 0x63.
- Implement SBOX as a 256-entry constant lookup function, instantiated four times in parallel.
- No byte reordering and no inter-byte interaction. Byte lane k in gives byte lane k out.
- Registered path: on each rising i_clk, if i_vld=1, o_wrd_sbox_r <= o_wrd_sbox. If i_vld=0, o_wrd_sbox_r holds its value.
- o_vld_r <= i_vld on every rising edge.
- There is no inverse S-box. This block is encrypt-direction only, which is all GCM needs.
- X or Z on any input byte gives X only on the corresponding output byte(s). No other lane is affected.

## Timing
- o_wrd_sbox is purely combinational with 0-cycle latency. It must settle within one cycle of i_wrd_sbox changing. A testbench may sample it after a #5 delay with no clock.
- o_wrd_sbox_r / o_vld_r have 1-cycle latency: the result is visible after the rising edge on which i_vld was sampled high.
- Back-to-back operation: i_vld may be high every cycle, giving full throughput of one word per cycle.
- Reset: while i_rst=1, o_wrd_sbox_r = 32'h0 and o_vld_r = 0, asynchronously and immediately, independent of i_clk.
- o_wrd_sbox is unaffected by reset and always tracks the input.
- Reset deasserted mid-stream: the first rising edge after deassertion samples i_vld/i_wrd_sbox normally.
- Reset asserted mid-operation: an in-flight registered result is discarded, with no partial state.
- No handshake back-pressure exists. The downstream stage must consume o_wrd_sbox_r on the cycle o_vld_r=1.

## Test plan
- FIPS-197 round-1 words driven combinationally, 5 time units apart:
  - 193de3be -> d42711ae
  - a0f4e22b -> e0bf98f1
  - 9ac68d2a -> b8b45de5
  - e9f84808 -> 1e415230
  - Concatenated 128-bit result must equal d42711aee0bf98f1b8b45de51e415230.
- Table corner bytes:
  - 00000000 -> 63636363
  - ffffffff -> 16161616
  - 00015300 -> 637ced63, which checks lane independence and position.
- Exhaustive: sweep each byte lane 00..ff with the other lanes fixed at 00. Compare against a reference SBOX model. The other lanes must read 63 throughout.
- Registered path:
  - Assert i_vld for 4 consecutive cycles with the round-1 words.
  - o_vld_r is high for exactly cycles 1..4.
  - o_wrd_sbox_r equals d42711ae, e0bf98f1, b8b45de5, 1e415230 in order.
  - With i_vld=0 afterwards, it holds 1e415230.
- Async reset:
  - Assert i_rst between clock edges while o_vld_r=1.
  - o_wrd_sbox_r=0 and o_vld_r=0 immediately.
  - o_wrd_sbox continues to show SBOX of the input.
  - After release, the next valid word appears one edge later.
